// File: rtl/md_pkg.sv
// Shared multiply/divide definitions.
// Holds the MDFunc operation codes used by the multiplier and the divider,
// and the divider state type.
package md_pkg;

  // MDFunc codes: bit 2 selects divide, bit 1 selects remainder, bit 0 selects unsigned
  localparam logic [2:0] MD_MUL    = 3'b000;
  localparam logic [2:0] MD_MULH   = 3'b001;
  localparam logic [2:0] MD_MULHSU = 3'b010;
  localparam logic [2:0] MD_MULHU  = 3'b011;
  localparam logic [2:0] MD_DIV    = 3'b100;
  localparam logic [2:0] MD_DIVU   = 3'b101;
  localparam logic [2:0] MD_REM    = 3'b110;
  localparam logic [2:0] MD_REMU   = 3'b111;

  typedef enum logic [2:0] {
    DIV_IDLE = 3'd0,
    DIV_PREP = 3'd1,
    DIV_ITER = 3'd2,
    DIV_FIX  = 3'd3,
    DIV_DONE = 3'd4
  } div_state_e;

  // True for any of the four divide/remainder codes
  function automatic logic md_is_div(input logic [2:0] func);
    return func[2];
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract division step (purely combinational).
// Ports:
//   i_rem  partial remainder          o_rem  next partial remainder
//   i_quo  dividend/quotient shifter  o_quo  shifter with new quotient bit in LSB
//   i_dvs  divisor magnitude
module div_step #(
  parameter int unsigned DWIDTH = 32
) (
  input  logic [DWIDTH-1:0] i_rem,
  input  logic [DWIDTH-1:0] i_quo,
  input  logic [DWIDTH-1:0] i_dvs,
  output logic [DWIDTH-1:0] o_rem,
  output logic [DWIDTH-1:0] o_quo
);

  logic [DWIDTH:0] w_shift;
  logic [DWIDTH:0] w_diff;
  logic            w_ge;

  // Bring the next dividend bit into the remainder; one extra bit avoids overflow on compare
  assign w_shift = {i_rem, i_quo[DWIDTH-1]};
  assign w_diff  = w_shift - {1'b0, i_dvs};
  assign w_ge    = (w_shift >= {1'b0, i_dvs});

  // Remainder always ends below the divisor, so it fits back in DWIDTH bits
  assign o_rem = w_ge ? DWIDTH'(w_diff) : DWIDTH'(w_shift);
  assign o_quo = {i_quo[DWIDTH-2:0], w_ge};

endmodule

// File: rtl/md_divider.sv
// Iterative restoring divider for DIV/DIVU/REM/REMU.
// Sequence IDLE -> PREP -> ITER (DWIDTH cycles) -> FIX -> DONE -> IDLE.
// Ports:
//   clock, reset  rising-edge clock, asynchronous active-high reset
//   A, B          dividend and divisor, latched when a start is accepted
//   MDFunc        operation code (1xx = divide family)
//   divEn         start request
//   DivOut        result, held until the next completion
//   divBusy       stall request (combinational)
//   divDone       one-cycle result-valid pulse
// Build option: define DIV_EARLY_OUT_EN to finish divide-by-zero and signed
// overflow directly from PREP.
module md_divider
  import md_pkg::*;
#(
  parameter int unsigned DWIDTH = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DWIDTH-1:0] A,
  input  logic [DWIDTH-1:0] B,
  input  logic [2:0]        MDFunc,
  input  logic              divEn,
  output logic [DWIDTH-1:0] DivOut,
  output logic              divBusy,
  output logic              divDone
);

  div_state_e        r_state;
  div_state_e        w_state_nxt;
  logic [DWIDTH-1:0] r_quo;
  logic [DWIDTH-1:0] r_rem;
  logic [DWIDTH-1:0] r_dvs;
  logic [DWIDTH-1:0] r_cnt;
  logic [1:0]        r_func;
  logic              r_qsign;
  logic              r_rsign;
  logic [DWIDTH-1:0] r_out;
  logic              r_done;

  logic              w_start;
  logic              w_signed;
  logic              w_a_neg;
  logic              w_b_neg;
  logic              w_dbz;
  logic              w_early;
  logic              w_last;
  logic [DWIDTH-1:0] w_rem_nxt;
  logic [DWIDTH-1:0] w_quo_nxt;
  logic [DWIDTH-1:0] w_q_fix;
  logic [DWIDTH-1:0] w_r_fix;
  logic [DWIDTH-1:0] w_result;

  assign w_start  = (r_state == DIV_IDLE) && divEn && md_is_div(MDFunc);
  assign w_signed = ~r_func[0];

  // In PREP r_quo/r_dvs still hold the raw operands
  assign w_a_neg = w_signed & r_quo[DWIDTH-1];
  assign w_b_neg = w_signed & r_dvs[DWIDTH-1];
  assign w_dbz   = (r_dvs == '0);
  assign w_last  = (r_cnt == DWIDTH'(DWIDTH - 1));

`ifdef DIV_EARLY_OUT_EN
  logic              w_ovf;
  logic [DWIDTH-1:0] w_early_res;

  assign w_ovf   = w_signed && (r_quo == {1'b1, (DWIDTH-1)'(0)}) && (r_dvs == '1);
  assign w_early = w_dbz | w_ovf;
  // Zero divisor: quotient all-ones, remainder A; overflow: quotient A, remainder 0
  assign w_early_res = r_func[1] ? (w_dbz ? r_quo : '0)
                                 : (w_dbz ? '1    : r_quo);
`else
  assign w_early = 1'b0;
`endif

  div_step #(
    .DWIDTH (DWIDTH)
  ) u_div_step (
    .i_rem (r_rem),
    .i_quo (r_quo),
    .i_dvs (r_dvs),
    .o_rem (w_rem_nxt),
    .o_quo (w_quo_nxt)
  );

  // Sign correction and quotient/remainder select
  assign w_q_fix  = r_qsign ? ('0 - r_quo) : r_quo;
  assign w_r_fix  = r_rsign ? ('0 - r_rem) : r_rem;
  assign w_result = r_func[1] ? w_r_fix : w_q_fix;

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= DIV_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      DIV_IDLE: if (w_start) w_state_nxt = DIV_PREP;
      DIV_PREP: w_state_nxt = w_early ? DIV_DONE : DIV_ITER;
      DIV_ITER: if (w_last) w_state_nxt = DIV_FIX;
      DIV_FIX:  w_state_nxt = DIV_DONE;
      DIV_DONE: w_state_nxt = DIV_IDLE;
      default:  w_state_nxt = DIV_IDLE;
    endcase
  end

  // Operand, sign, counter and result registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_quo   <= '0;
      r_rem   <= '0;
      r_dvs   <= '0;
      r_cnt   <= '0;
      r_func  <= '0;
      r_qsign <= 1'b0;
      r_rsign <= 1'b0;
      r_out   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= (w_state_nxt == DIV_DONE);
      case (r_state)
        DIV_IDLE: begin
          if (w_start) begin
            r_quo  <= A;
            r_dvs  <= B;
            r_func <= MDFunc[1:0];
          end
        end
        DIV_PREP: begin
          r_quo   <= w_a_neg ? ('0 - r_quo) : r_quo;
          r_dvs   <= w_b_neg ? ('0 - r_dvs) : r_dvs;
          // A zero divisor keeps the all-ones quotient un-negated; remainder then equals A
          r_qsign <= (w_a_neg ^ w_b_neg) & ~w_dbz;
          r_rsign <= w_a_neg;
          r_rem   <= '0;
          r_cnt   <= '0;
`ifdef DIV_EARLY_OUT_EN
          if (w_early) r_out <= w_early_res;
`endif
        end
        DIV_ITER: begin
          r_rem <= w_rem_nxt;
          r_quo <= w_quo_nxt;
          r_cnt <= r_cnt + DWIDTH'(1);
        end
        DIV_FIX: begin
          r_out <= w_result;
        end
        default: ;
      endcase
    end
  end

  assign divBusy = w_start || (r_state == DIV_PREP) || (r_state == DIV_ITER) ||
                   (r_state == DIV_FIX);
  assign DivOut  = r_out;
  assign divDone = r_done;

endmodule

// File: doc/md_divider.md
MD_DIVIDER -- requirements
Module: md_divider

Interface
REQ-001 The block SHALL have parameter DWIDTH, default 32, giving the operand and result width.
REQ-002 The block SHALL have port clock, input, 1 bit: the single clock; all state SHALL change on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port A, input, DWIDTH bits: dividend (rs1).
REQ-005 The block SHALL have port B, input, DWIDTH bits: divisor (rs2).
REQ-006 The block SHALL have port MDFunc, input, 3 bits: 100=DIV, 101=DIVU, 110=REM, 111=REMU; codes 0xx are not division.
REQ-007 The block SHALL have port divEn, input, 1 bit: start request.
REQ-008 The block SHALL have port DivOut, output, DWIDTH bits: result.
REQ-009 The block SHALL have port divBusy, output, 1 bit: pipeline stall request.
REQ-010 The block SHALL have port divDone, output, 1 bit: single-cycle result-valid pulse.

Function
REQ-011 States SHALL be IDLE, PREP, ITER, FIX and DONE.
REQ-012 A start SHALL be accepted only in IDLE with divEn=1 and MDFunc[2]=1; on acceptance A, B and MDFunc SHALL be latched, and the next state SHALL be PREP.
REQ-013 divEn while not in IDLE, or with MDFunc[2]=0, SHALL be ignored; operand changes after acceptance SHALL have no effect.
REQ-014 PREP SHALL last 1 cycle: for DIV/REM, take the absolute values of the operands and record the quotient sign (A xor B) and the remainder sign (A); for DIVU/REMU, pass the operands unchanged.
REQ-015 ITER SHALL last exactly DWIDTH cycles, one restoring shift-subtract step per cycle, using a DWIDTH-bit iteration counter that is 0 on ITER entry and exits ITER at count DWIDTH-1.
REQ-016 FIX SHALL last 1 cycle: negate the quotient and/or remainder per the recorded signs, then select the quotient for DIV/DIVU or the remainder for REM/REMU into DivOut.
REQ-017 DONE SHALL last 1 cycle with divDone=1, then return to IDLE; divDone SHALL be 1 only in DONE.
REQ-018 Latency SHALL be DWIDTH+3 cycles from the acceptance edge to divDone high (35 cycles for DWIDTH=32).
REQ-019 divBusy SHALL be combinationally 1 in IDLE when a valid start is present, and 1 in PREP, ITER and FIX; it SHALL be 0 in DONE and otherwise in IDLE.
REQ-020 DivOut SHALL hold its last result until the next DONE; it SHALL be 0 before the first result.
REQ-021 Divide by zero SHALL give quotient all-ones and remainder equal to A, for both signed and unsigned forms.
REQ-022 Signed overflow (A=most-negative, B=-1) SHALL give quotient equal to A and remainder 0.
REQ-023 A start presented in the DONE cycle SHALL be ignored; the requester re-presents it in the following IDLE cycle.

Reset
REQ-024 Assertion of reset SHALL force, asynchronously: state=IDLE, DivOut=0, divBusy=0, divDone=0, and clear all internal registers.
REQ-025 Reset in any mid-operation state SHALL abort the operation with no divDone pulse; the first accepted start after reset release SHALL behave as from power-up.

Configuration
REQ-026 Macro DIV_EARLY_OUT_EN SHALL, when defined, route divide-by-zero and signed overflow from PREP directly to DONE with the REQ-021/REQ-022 results (divDone high 2 cycles after acceptance).
REQ-027 When DIV_EARLY_OUT_EN is undefined, all operations SHALL take the full REQ-018 latency and still produce REQ-021/REQ-022 results.

Structure
REQ-028 Shared package md_pkg SHALL hold the MDFunc code constants (shared with the multiplier) and the divider state enum type.
REQ-029 Sub-module div_step SHALL be combinational: one restoring step (remainder, quotient, divisor in; next remainder and quotient out).
REQ-030 md_divider SHALL hold the FSM, counter, sign and operand registers, and the output registers.

Verification
REQ-031 DIVU A=100, B=7 -> DivOut=14, divDone in cycle 35 after acceptance, divBusy high throughout.
REQ-032 DIV A=-7, B=2 -> DivOut=-3 (0xFFFFFFFD); REM A=-7, B=2 -> DivOut=-1 (0xFFFFFFFF).
REQ-033 DIV A=5, B=0 -> 0xFFFFFFFF; REMU A=5, B=0 -> 5; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 and REM -> 0; latency 2 with DIV_EARLY_OUT_EN, 35 without.
REQ-034 Start DIVU 100/7, change A and B mid-ITER, pulse divEn again -> result still 14, second request ignored.
REQ-035 Assert reset at ITER count 10 -> outputs 0, no divDone; next DIVU 9/3 -> 3 at normal latency.
